// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl_if
// Purpose  : Bundles the instruction-ROM bus, control inputs (redirect/halt)
//            and the decode-side valid/ready handshake of the fetch
//            controller.
//            master = fetch controller view.
//            slave  = ROM/decode environment view.
// Revision : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 6
);
    // ROM bus
    logic [BUS_WIDTH-1:0]  imem_addr;
    logic [DATA_WIDTH-1:0] imem_rdata;
    // Control
    logic                  redirect_valid;
    logic [BUS_WIDTH-1:0]  redirect_addr;
    logic                  halt;
    // Decode handshake
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [BUS_WIDTH-1:0]  inst_pc;
    logic                  halted;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_addr,
        input  halt,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc,
        output halted
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_addr,
        output halt,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc,
        input  halted
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Purpose  : Instruction fetch controller. Owns the PC and drives the ROM
//            word address. Captures combinational ROM data into a 2-entry
//            prefetch FIFO that feeds decode via valid/ready. Supports
//            redirect (flush + new PC) and halt.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int BUS_WIDTH  = 6,
    parameter int RESET_PC   = 0
) (
    input  wire                     clk,
    input  wire                     rst_n,
    imem_fetch_ctrl_if.master       bus
);

    localparam logic [BUS_WIDTH-1:0] c_reset_pc = RESET_PC[BUS_WIDTH-1:0];
    localparam logic [BUS_WIDTH-1:0] c_pc_one   = {{(BUS_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [1:0]           c_cnt_full = 2'd2;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BUS_WIDTH-1:0]  r_pc;
    logic [1:0]            r_count;
    // Entry 0 is always the FIFO head; entry 1 is the tail slot when full.
    logic [BUS_WIDTH-1:0]  r_pc0;
    logic [BUS_WIDTH-1:0]  r_pc1;
    logic [DATA_WIDTH-1:0] r_inst0;
    logic [DATA_WIDTH-1:0] r_inst1;

    logic                  w_pop;
    logic                  w_push;

    // The push gate samples halt directly so no fetch starts on the cycle
    // halt first rises, before the FSM has reached HALT.
    assign w_pop  = (r_count != 2'd0) & bus.inst_ready;
    assign w_push = (r_state == ST_RUN) & ~bus.halt & ~bus.redirect_valid &
                    ((r_count < c_cnt_full) | w_pop);

    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = (r_count != 2'd0);
    assign bus.inst_data  = r_inst0;
    assign bus.inst_pc    = r_pc0;
    assign bus.halted     = (r_state == ST_HALT);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect blocks entry to HALT but not the exit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (bus.halt && !bus.redirect_valid) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!bus.halt) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // PC and prefetch FIFO; redirect overrides any push and discards entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= c_reset_pc;
            r_count <= 2'd0;
            r_pc0   <= '0;
            r_pc1   <= '0;
            r_inst0 <= '0;
            r_inst1 <= '0;
        end else if (bus.redirect_valid) begin
            r_pc    <= bus.redirect_addr;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_pc <= r_pc + c_pc_one;
            end
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0   <= r_pc;
                        r_inst0 <= bus.imem_rdata;
                    end else begin
                        r_pc1   <= r_pc;
                        r_inst1 <= bus.imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_pc0   <= r_pc1;
                    r_inst0 <= r_inst1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind the
                    // surviving entry (if any).
                    if (r_count == 2'd1) begin
                        r_pc0   <= r_pc;
                        r_inst0 <= bus.imem_rdata;
                    end else begin
                        r_pc0   <= r_pc1;
                        r_inst0 <= r_inst1;
                        r_pc1   <= r_pc;
                        r_inst1 <= bus.imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Purpose  : Directed self-checking bench for imem_fetch_ctrl with a
//            combinational ROM model ROM[i] = 0x1000_0000 + i.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int DW = 32;
    localparam int BW = 6;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    imem_fetch_ctrl_if #(.DATA_WIDTH(DW), .BUS_WIDTH(BW)) bus ();

    imem_fetch_ctrl #(
        .DATA_WIDTH (DW),
        .BUS_WIDTH  (BW),
        .RESET_PC   (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ROM model.
    assign bus.imem_rdata = 32'h1000_0000 + {26'd0, bus.imem_addr};

    // Clock generation.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the head (pc and ROM word) when valid, plus the ROM address.
    task automatic head(input string tag, input logic v, input logic [BW-1:0] pc,
                        input logic [BW-1:0] addr, input logic hlt);
        chk({tag, ".valid"}, bus.inst_valid, v);
        if (v) begin
            chk({tag, ".pc"},   bus.inst_pc, pc);
            chk({tag, ".data"}, bus.inst_data, 32'h1000_0000 + {26'd0, pc});
        end
        chk({tag, ".addr"},   bus.imem_addr, addr);
        chk({tag, ".halted"}, bus.halted, hlt);
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = '0;
        bus.halt           = 1'b0;
        bus.inst_ready     = 1'b1;

        // Reset state.
        #12;
        chk("rst.valid",  bus.inst_valid, 1'b0);
        chk("rst.data",   bus.inst_data, 32'h0);
        chk("rst.pc",     bus.inst_pc, 6'h0);
        chk("rst.addr",   bus.imem_addr, 6'h0);
        chk("rst.halted", bus.halted, 1'b0);

        // Stream: head k-1 visible after edge k, address one ahead.
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            head($sformatf("stream%0d", k), 1'b1, BW'(k - 1), BW'(k), 1'b0);
        end

        // Backpressure: buffer fills with 3,4 and PC freezes at 5.
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            head($sformatf("bp%0d", k), 1'b1, 6'd3, 6'd5, 1'b0);
        end
        bus.inst_ready = 1'b1;
        tick(); head("bprel0", 1'b1, 6'd4, 6'd6, 1'b0);
        tick(); head("bprel1", 1'b1, 6'd5, 6'd7, 1'b0);
        tick(); head("bprel2", 1'b1, 6'd6, 6'd8, 1'b0);

        // Redirect with a full buffer {6,7}: entries discarded, 2-cycle bubble.
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 6'h20;
        tick(); head("redir0", 1'b0, 6'h00, 6'h20, 1'b0);
        bus.redirect_valid = 1'b0;
        bus.redirect_addr  = 6'h11;
        bus.inst_ready     = 1'b1;
        tick(); head("redir1", 1'b1, 6'h20, 6'h21, 1'b0);
        tick(); head("redir2", 1'b1, 6'h21, 6'h22, 1'b0);

        // Wrap around the top of the address space.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 6'h3E;
        tick(); head("wrap0", 1'b0, 6'h00, 6'h3E, 1'b0);
        bus.redirect_valid = 1'b0;
        tick(); head("wrap1", 1'b1, 6'h3E, 6'h3F, 1'b0);
        tick(); head("wrap2", 1'b1, 6'h3F, 6'h00, 1'b0);
        tick(); head("wrap3", 1'b1, 6'h00, 6'h01, 1'b0);
        tick(); head("wrap4", 1'b1, 6'h01, 6'h02, 1'b0);

        // Halt: fill {6,7} with PC=8, then halt and let the buffer drain.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 6'h06;
        bus.inst_ready     = 1'b0;
        tick(); head("hsetup0", 1'b0, 6'h00, 6'h06, 1'b0);
        bus.redirect_valid = 1'b0;
        tick(); head("hsetup1", 1'b1, 6'h06, 6'h07, 1'b0);
        tick(); head("hsetup2", 1'b1, 6'h06, 6'h08, 1'b0);
        bus.halt       = 1'b1;
        bus.inst_ready = 1'b1;
        tick(); head("halt0", 1'b1, 6'h07, 6'h08, 1'b1);
        tick(); head("halt1", 1'b0, 6'h00, 6'h08, 1'b1);
        tick(); head("halt2", 1'b0, 6'h00, 6'h08, 1'b1);
        bus.halt = 1'b0;
        tick(); head("resume0", 1'b0, 6'h00, 6'h08, 1'b0);
        tick(); head("resume1", 1'b1, 6'h08, 6'h09, 1'b0);
        tick(); head("resume2", 1'b1, 6'h09, 6'h0A, 1'b0);

        // Async reset mid-stream at PC=0x15.
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = 6'h13;
        tick(); head("arst0", 1'b0, 6'h00, 6'h13, 1'b0);
        bus.redirect_valid = 1'b0;
        tick(); head("arst1", 1'b1, 6'h13, 6'h14, 1'b0);
        tick(); head("arst2", 1'b1, 6'h14, 6'h15, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.valid",  bus.inst_valid, 1'b0);
        chk("arst.data",   bus.inst_data, 32'h0);
        chk("arst.pc",     bus.inst_pc, 6'h0);
        chk("arst.addr",   bus.imem_addr, 6'h0);
        chk("arst.halted", bus.halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(); head("restart0", 1'b1, 6'h00, 6'h01, 1'b0);
        tick(); head("restart1", 1'b1, 6'h01, 6'h02, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
